// File: rtl/fc_pkg.sv
// Shared FSM states, adjust-direction encodings and duration helpers for fc_lock_ctrl.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_ADJUST  = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } fc_state_e;

  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] DEC  = 2'b10;
  localparam logic [1:0] HOLD = 2'b00;

  localparam int DUR_W = 16;

  function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] d);
    if (d == {DUR_W{1'b1}}) begin
      dur_sat_inc = d;
    end else begin
      dur_sat_inc = d + 16'd1;
    end
  endfunction

endpackage

// File: rtl/fc_edge_counter.sv
// Brings clk_ex into the clk domain and counts its rising edges while enabled.
// The count saturates at all-ones; edges faster than clk/2 are undercounted.
module fc_edge_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_ex,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] total
);

  logic         sync_a_r;
  logic         sync_b_r;
  logic         prev_r;
  logic [W-1:0] cnt_r;
  logic         rise_s;

  // two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a_r <= 1'b0;
      sync_b_r <= 1'b0;
      prev_r   <= 1'b0;
    end else begin
      sync_a_r <= clk_ex;
      sync_b_r <= sync_a_r;
      prev_r   <= sync_b_r;
    end
  end

  assign rise_s = sync_b_r & ~prev_r;

  // running total including an edge seen in the current cycle
  always_comb begin
    total = cnt_r;
    if (en && rise_s && (cnt_r != {W{1'b1}})) begin
      total = cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      total = cnt_r;
    end
  end

  // edge accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= total;
    end
  end

endmodule

// File: rtl/fc_lock_ctrl.sv
// Frequency lock controller: measures clk_ex over a gate window and steps the trim code.
// Optional FC_TRACK_EN: keep measuring after lock and re-adjust when lock is lost.
module fc_lock_ctrl
  import fc_pkg::*;
#(
  parameter int W        = 8,
  parameter int GATE_LEN = 256,
  parameter int TOL      = 2,
  parameter int MAX_WIN  = 64
) (
  input  logic             clk50,
  input  logic             rst_r,
  input  logic             clk_ex,
  input  logic             start,
  input  logic [W-1:0]     set_point,
  input  logic [W-1:0]     min_code,
  input  logic [W-1:0]     max_code,
  input  logic [W-1:0]     init_code,
  input  logic [W-1:0]     step,
  output logic [W-1:0]     code,
  output logic [W-1:0]     count,
  output logic             meas_valid,
  output logic [1:0]       inc_dec,
  output logic             locked,
  output logic             fail,
  output logic [DUR_W-1:0] duration
);

  localparam int                TW        = $clog2(GATE_LEN);
  localparam logic [TW-1:0]     LAST_TICK = TW'(GATE_LEN - 1);
  localparam logic [W:0]        TOL_X     = (W+1)'(TOL);
  localparam logic [DUR_W-1:0]  MAX_WIN_D = DUR_W'(MAX_WIN);

  fc_state_e      state_r;
  logic [TW-1:0]  win_r;
  logic [W-1:0]   total_s;
  logic           meas_en_s;
  logic [W:0]     count_x_s;
  logic [W:0]     sp_x_s;
  logic           in_tol_s;
  logic           too_low_s;
  logic           too_high_s;
  logic           budget_out_s;
  logic [W:0]     up_sum_s;
  logic [W-1:0]   up_code_s;
  logic [W-1:0]   dn_code_s;
  logic [W-1:0]   init_clamp_s;

  assign meas_en_s = (state_r == ST_MEASURE);

  fc_edge_counter #(.W(W)) u_edge_counter (
    .clk    (clk50),
    .rst_n  (rst_r),
    .clk_ex (clk_ex),
    .en     (meas_en_s),
    .clr    (~meas_en_s),
    .total  (total_s)
  );

  // one guard bit keeps set_point +/- TOL from wrapping
  assign count_x_s    = {1'b0, count};
  assign sp_x_s       = {1'b0, set_point};
  assign in_tol_s     = ((count_x_s + TOL_X) >= sp_x_s) && (count_x_s <= (sp_x_s + TOL_X));
  assign too_low_s    = (count_x_s + TOL_X) < sp_x_s;
  assign too_high_s   = count_x_s > (sp_x_s + TOL_X);
  assign budget_out_s = (duration == MAX_WIN_D) && !locked;
  assign up_sum_s     = {1'b0, code} + {1'b0, step};

  // next code candidates, clamped to the programmed bounds
  always_comb begin
    if (up_sum_s > {1'b0, max_code}) begin
      up_code_s = max_code;
    end else begin
      up_code_s = up_sum_s[W-1:0];
    end
    if ({1'b0, code} < ({1'b0, min_code} + {1'b0, step})) begin
      dn_code_s = min_code;
    end else begin
      dn_code_s = code - step;
    end
    if (init_code < min_code) begin
      init_clamp_s = min_code;
    end else if (init_code > max_code) begin
      init_clamp_s = max_code;
    end else begin
      init_clamp_s = init_code;
    end
  end

  // control FSM with registered outputs
  always_ff @(posedge clk50 or negedge rst_r) begin
    if (!rst_r) begin
      state_r    <= ST_IDLE;
      win_r      <= {TW{1'b0}};
      code       <= {W{1'b0}};
      count      <= {W{1'b0}};
      meas_valid <= 1'b0;
      inc_dec    <= HOLD;
      locked     <= 1'b0;
      fail       <= 1'b0;
      duration   <= {DUR_W{1'b0}};
    end else begin
      meas_valid <= 1'b0;
      if (!start) begin
        state_r <= ST_IDLE;
        win_r   <= {TW{1'b0}};
        inc_dec <= HOLD;
        locked  <= 1'b0;
        fail    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_LOAD;
          end
          ST_LOAD: begin
            win_r    <= {TW{1'b0}};
            duration <= {DUR_W{1'b0}};
            locked   <= 1'b0;
            inc_dec  <= HOLD;
            if (min_code > max_code) begin
              fail    <= 1'b1;
              state_r <= ST_FAIL;
            end else begin
              fail    <= 1'b0;
              code    <= init_clamp_s;
              state_r <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (win_r == LAST_TICK) begin
              win_r      <= {TW{1'b0}};
              count      <= total_s;
              meas_valid <= 1'b1;
              duration   <= dur_sat_inc(duration);
              state_r    <= ST_ADJUST;
            end else begin
              win_r <= win_r + TW'(1);
            end
          end
          ST_ADJUST: begin
            if (in_tol_s) begin
              locked  <= 1'b1;
              inc_dec <= HOLD;
              state_r <= ST_LOCKED;
            end else begin
`ifdef FC_TRACK_EN
              if (locked) begin
                locked   <= 1'b0;
                duration <= {DUR_W{1'b0}};
              end
`endif
              if (budget_out_s) begin
                fail    <= 1'b1;
                inc_dec <= HOLD;
                state_r <= ST_FAIL;
              end else if (too_low_s && (code != max_code)) begin
                inc_dec <= INC;
                code    <= up_code_s;
                state_r <= ST_MEASURE;
              end else if (too_high_s && (code != min_code)) begin
                inc_dec <= DEC;
                code    <= dn_code_s;
                state_r <= ST_MEASURE;
              end else begin
                // code already pinned at the bound it needs to move past
                fail    <= 1'b1;
                inc_dec <= HOLD;
                state_r <= ST_FAIL;
              end
            end
          end
          ST_LOCKED: begin
`ifdef FC_TRACK_EN
            state_r <= ST_MEASURE;
`else
            state_r <= ST_LOCKED;
`endif
          end
          ST_FAIL: begin
            state_r <= ST_FAIL;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_lock_ctrl.sv
// Directed bench for fc_lock_ctrl; the tracking scenario runs when FC_TRACK_EN is defined.
`timescale 1ns/1ps
module tb_fc_lock_ctrl;

  logic        clk50 = 1'b0;
  logic        rst_r;
  logic        clk_ex = 1'b0;
  logic        start;
  logic [7:0]  set_point, min_code, max_code, init_code, step;
  logic [7:0]  code, count;
  logic        meas_valid;
  logic [1:0]  inc_dec;
  logic        locked, fail;
  logic [15:0] duration;

  int  total = 0;
  int  bad   = 0;
  int  n;
  bit  osc_track  = 1'b0;
  real osc_scale  = 1.0;
  real fixed_half = 20.0;
  real half_ns;

  fc_lock_ctrl dut (
    .clk50(clk50), .rst_r(rst_r), .clk_ex(clk_ex), .start(start),
    .set_point(set_point), .min_code(min_code), .max_code(max_code),
    .init_code(init_code), .step(step), .code(code), .count(count),
    .meas_valid(meas_valid), .inc_dec(inc_dec), .locked(locked),
    .fail(fail), .duration(duration)
  );

  always #10 clk50 = ~clk50;

  // oscillator: fixed period, or edges-per-window equal to code/osc_scale
  always begin
    if (osc_track) begin
      if (code == 8'd0) half_ns = 25.0;
      else half_ns = 2560.0 * osc_scale / real'(code);
    end else begin
      half_ns = fixed_half;
    end
    #(half_ns) clk_ex = ~clk_ex;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input logic [31:0] lo, input logic [31:0] hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk50);
  endtask

  task automatic wait_mv(input string tag, input int budget, output int cnt);
    cnt = 0;
    while (meas_valid !== 1'b1 && cnt < budget) begin
      @(negedge clk50);
      cnt++;
    end
    total++;
    assert (meas_valid === 1'b1) else begin
      bad++;
      $error("FAIL %s: observed=no meas_valid after %0d cycles expected=meas_valid", tag, cnt);
    end
  endtask

  task automatic quiet(input string tag, input int k);
    logic seen;
    seen = 1'b0;
    repeat (k) begin
      @(negedge clk50);
      if (meas_valid === 1'b1) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_code"}, {24'd0, code}, 32'd0);
    chk({pfx, "_count"}, {24'd0, count}, 32'd0);
    chk({pfx, "_mv"}, {31'd0, meas_valid}, 32'd0);
    chk({pfx, "_incdec"}, {30'd0, inc_dec}, 32'd0);
    chk({pfx, "_locked"}, {31'd0, locked}, 32'd0);
    chk({pfx, "_fail"}, {31'd0, fail}, 32'd0);
    chk({pfx, "_dur"}, {16'd0, duration}, 32'd0);
  endtask

  initial begin
    rst_r = 1'b0; start = 1'b0;
    set_point = 8'd128; min_code = 8'd0; max_code = 8'd255;
    init_code = 8'd100; step = 8'd4;
    #5;
    check_zero("reset");
    @(negedge clk50); rst_r = 1'b1;
    cyc(2);

    // fixed 40ns oscillator: 128 edges per window, locks on the first window
    start = 1'b1;
    wait_mv("t1_wait", 400, n);
    chk("t1_latency", n, 32'd258);
    chk_rng("t1_count", {24'd0, count}, 32'd127, 32'd129);
    chk("t1_dur", {16'd0, duration}, 32'd1);
    chk("t1_code", {24'd0, code}, 32'd100);
    cyc(1);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_incdec", {30'd0, inc_dec}, 32'd0);
    chk("t1_fail", {31'd0, fail}, 32'd0);
`ifndef FC_TRACK_EN
    quiet("t1_locked_quiet", 600);
    chk("t1_locked_hold", {31'd0, locked}, 32'd1);
`endif
    start = 1'b0;
    cyc(1);
    chk("t1_stop_locked", {31'd0, locked}, 32'd0);
    chk("t1_stop_code", {24'd0, code}, 32'd100);
    cyc(2);

    // code-driven oscillator: climbs 100 -> 120 in steps of 4, then locks
    set_point = 8'd120; osc_track = 1'b1; osc_scale = 1.0;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_mv("t2_wait", 400, n);
      cyc(1);
      chk("t2_incdec", {30'd0, inc_dec}, 32'd1);
      chk("t2_code", {24'd0, code}, 32'd104 + 32'd4 * k);
    end
    wait_mv("t2_wait_lock", 400, n);
    cyc(1);
    chk("t2_locked", {31'd0, locked}, 32'd1);
    chk("t2_fail", {31'd0, fail}, 32'd0);
    chk("t2_dur", {16'd0, duration}, 32'd6);
    chk("t2_code_lock", {24'd0, code}, 32'd120);

`ifdef FC_TRACK_EN
    // slow the oscillator by 20%: lock drops, code climbs until it relocks
    wait_mv("t6_wait", 400, n);
    osc_scale = 1.25;
    cyc(1);
    wait_mv("t6_wait_loss", 400, n);
    cyc(1);
    chk("t6_lost", {31'd0, locked}, 32'd0);
    chk("t6_incdec", {30'd0, inc_dec}, 32'd1);
    chk("t6_code", {24'd0, code}, 32'd124);
    n = 0;
    while (locked !== 1'b1 && n < 6000) begin
      @(negedge clk50);
      n++;
    end
    chk("t6_relock", {31'd0, locked}, 32'd1);
    chk("t6_fail", {31'd0, fail}, 32'd0);
    chk_rng("t6_code_relock", {24'd0, code}, 32'd148, 32'd152);
    chk_rng("t6_dur", {16'd0, duration}, 32'd7, 32'd8);
    osc_scale = 1.0;
`endif

    start = 1'b0;
    cyc(2);

    // unreachable target: code clamps at max_code and then fails
    set_point = 8'd250; max_code = 8'd110;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_mv("t3_wait", 400, n);
      cyc(1);
      chk("t3_incdec", {30'd0, inc_dec}, 32'd1);
      chk("t3_code", {24'd0, code}, (k == 0) ? 32'd104 : (k == 1) ? 32'd108 : 32'd110);
    end
    wait_mv("t3_wait_fail", 400, n);
    cyc(1);
    chk("t3_fail", {31'd0, fail}, 32'd1);
    chk("t3_locked", {31'd0, locked}, 32'd0);
    chk("t3_code_hold", {24'd0, code}, 32'd110);
    quiet("t3_fail_quiet", 300);
    chk("t3_fail_hold", {31'd0, fail}, 32'd1);
    start = 1'b0;
    cyc(1);
    chk("t3_stop_fail", {31'd0, fail}, 32'd0);
    cyc(1);

    // start dropped mid-MEASURE, then restarted with a new init_code
    max_code = 8'd255;
    start = 1'b1;
    wait_mv("t4_wait", 400, n);
    cyc(50);
    chk("t4_dur_before", {16'd0, duration}, 32'd1);
    start = 1'b0;
    cyc(1);
    chk("t4_locked", {31'd0, locked}, 32'd0);
    chk("t4_incdec", {30'd0, inc_dec}, 32'd0);
    chk("t4_code_hold", {24'd0, code}, 32'd104);
    quiet("t4_idle_quiet", 300);
    init_code = 8'd90;
    start = 1'b1;
    cyc(2);
    chk("t4_reload", {24'd0, code}, 32'd90);
    chk("t4_dur_restart", {16'd0, duration}, 32'd0);

    // init below min clamps up; min above max fails out of LOAD
    start = 1'b0; cyc(2);
    init_code = 8'd5; min_code = 8'd20;
    start = 1'b1; cyc(2);
    chk("clamp_min", {24'd0, code}, 32'd20);
    start = 1'b0; cyc(2);
    min_code = 8'd200; max_code = 8'd100;
    start = 1'b1; cyc(2);
    chk("bad_bounds_fail", {31'd0, fail}, 32'd1);
    cyc(3);
    chk("bad_bounds_hold", {31'd0, fail}, 32'd1);
    start = 1'b0; cyc(2);

    // asynchronous reset while in ADJUST
    min_code = 8'd0; max_code = 8'd255; init_code = 8'd100;
    start = 1'b1;
    wait_mv("t5_wait", 400, n);
    #3 rst_r = 1'b0;
    #1 check_zero("t5_async");
    start = 1'b0;
    @(negedge clk50); rst_r = 1'b1;
    cyc(3);
    chk("t5_idle_code", {24'd0, code}, 32'd0);
    chk("t5_idle_mv", {31'd0, meas_valid}, 32'd0);
    start = 1'b1;
    cyc(2);
    chk("t5_reload", {24'd0, code}, 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_lock_ctrl.md
Name: fc_lock_ctrl

Overview:
- Parametrised successor to the fc2 frequency-counter/controller.
- Measures an asynchronous oscillator clock (clk_ex) over a programmable gate window of clk50 cycles.
- Compares the edge count against a set point with a tolerance band, then steps a W-bit oscillator control code up or down between min/max bounds until it locks or fails.
- Sits between the ring-oscillator trim input and the system controller.

Parameters:
- W, 8, width of set point, bounds, control code and edge count.
- GATE_LEN, 256, clk50 cycles per measurement window (>=4).
- TOL, 2, allowed |count - set_point| for lock.
- MAX_WIN, 64, windows allowed before fail.

Ports:
- clk50  in  1  system clock, all logic on rising edge.
- rst_r  in  1  asynchronous active-low reset.
- clk_ex  in  1  oscillator clock, asynchronous to clk50.
- start  in  1  level enable; low forces IDLE.
- set_point  in  W  target edges per window.
- min_code  in  W  lower code bound.
- max_code  in  W  upper code bound.
- init_code  in  W  code loaded at start.
- step  in  W  code increment/decrement per adjust.
- code  out  W  current oscillator control code.
- count  out  W  last completed window edge count.
- meas_valid  out  1  one-cycle pulse when count updates.
- inc_dec  out  2  01=increment, 10=decrement, 00=hold; valid with meas_valid.
- locked  out  1  count within tolerance.
- fail  out  1  bound hit or window budget exhausted.
- duration  out  16  windows since start, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_r=0, async): state IDLE. code=0, count=0, inc_dec=00, meas_valid=0, locked=0, fail=0, duration=0.
- clk_ex path: 2-flop synchroniser, then rising-edge detect in clk50. Edge counter saturates at all-ones. clk_ex above clk50/2 undercounts; that is documented, not flagged.
- FSM states: IDLE, LOAD, MEASURE, ADJUST, LOCKED, FAIL.
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): code=clamp(init_code, min_code, max_code); clear counter, window timer, duration, locked, fail -> MEASURE.
  - MEASURE: runs exactly GATE_LEN cycles. At the last cycle, count<=edge total, meas_valid=1, duration++ -> ADJUST.
  - ADJUST (1 cycle), in priority order:
    - |count-set_point|<=TOL: locked=1, inc_dec=00 -> LOCKED.
    - duration==MAX_WIN: fail=1 -> FAIL.
    - count<set_point-TOL: if code==max_code, fail=1 -> FAIL; else inc_dec=01, code=min(code+step, max_code) -> MEASURE.
    - count>set_point+TOL: if code==min_code, fail=1 -> FAIL; else inc_dec=10, code=max(code-step, min_code) -> MEASURE.
- Arithmetic: comparisons use W+1 bits, so set_point±TOL does not wrap. code±step is computed at W+1 bits, then clamped.
- LOCKED and FAIL hold all outputs until start=0.
- start=0 in any state: -> IDLE next cycle. code and count hold; locked, fail and inc_dec clear.
- Restart with start=1 always passes through LOAD.
- min_code>max_code: fail=1 in LOAD -> FAIL.

Optional Feature:
- Macro: FC_TRACK_EN.
- Defined: LOCKED re-enters MEASURE continuously. An in-tolerance window keeps locked=1. An out-of-tolerance window clears locked and resumes adjusting; duration restarts at 0 on lock loss.
- Undefined: LOCKED is terminal until start=0. No further measurement; meas_valid stays 0.

Decomposition:
- Package fc_pkg: state enum, INC=2'b01, DEC=2'b10, HOLD=2'b00, duration width constant 16.
- Sub-module fc_edge_counter: synchroniser, edge detect, saturating W-bit counter with clear. Parameter W.

Test Plan:
- Defaults, clk_ex period 40ns (128 edges/window), set_point=128, init_code=100 -> first meas_valid after 256 cycles, count in 127..129, locked=1, duration=1, code=100.
- Bench oscillator whose frequency rises with code; set_point=150, init=100, step=4 -> repeated inc_dec=01, code rising by 4; lock within MAX_WIN; fail=0.
- Unreachable set_point=250, max_code=110, init=100, step=4 -> code steps 104, 108, 110 (clamped), then fail=1; code holds 110.
- start dropped mid-MEASURE, then reasserted -> IDLE next cycle, locked=0; LOAD reloads init_code; duration restarts at 0.
- rst_r pulsed low mid-ADJUST, asynchronous to clk50 -> all outputs zero immediately, state IDLE.
- With FC_TRACK_EN: after lock, change oscillator period by 20% -> locked drops at the next meas_valid; adjusting resumes and relocks.
